aq_f_spsram_ctrl_64x98: RTL and testbench

- Requester-side controller for the 64x98 single-port SRAM wrapper.
- Converts a valid/ready request channel (read/write with bit mask) into the wrapper's CEN/GWEN/WEN/A/D pins.
- Captures the 1-cycle-latency Q into an in-order valid/ready response channel, with a one-entry hold register for response backpressure.
- Optionally zero-fills the array after reset before accepting traffic.

---
 rtl/aq_f_spsram_ctrl_64x98.sv | 133 +++++++++++++
 tb/tb_aq_f_spsram_ctrl_64x98.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_f_spsram_ctrl_64x98.sv
`default_nettype none
// ============================================================================
// Module  : aq_f_spsram_ctrl_64x98
// Brief   : Valid/ready requester for the 64x98 single-port SRAM wrapper with
//           an in-order read response channel and a one-entry hold register.
//           Define AQ_SPSRAM_CTRL_INIT_EN to zero-fill the array after reset.
// Rev     : 1.0 - initial release
// ============================================================================
module aq_f_spsram_ctrl_64x98 #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 98
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    logic                  r_infl;
    logic                  r_hold_vld;
    logic [DATA_WIDTH-1:0] r_hold_q;
    logic                  w_run;
    logic                  w_init;
    logic [ADDR_WIDTH-1:0] w_init_a;
    logic                  w_rd_ok;
    logic                  w_acc;
    logic                  w_capture;

`ifdef AQ_SPSRAM_CTRL_INIT_EN
    localparam logic [0:0]            c_st_init   = 1'b0;
    localparam logic [0:0]            c_st_run    = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
    localparam logic [ADDR_WIDTH-1:0] c_cnt_one   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= c_st_init;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_init) begin
                r_init_cnt <= r_init_cnt + c_cnt_one;
            end
        end
    end

    // Leave INIT right after the write to the last word has been issued.
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == c_st_init) && (r_init_cnt == c_last_addr)) begin
            w_state_nxt = c_st_run;
        end
    end

    assign w_run    = (r_state == c_st_run) & ~RST;
    assign w_init   = (r_state == c_st_init) & ~RST;
    assign w_init_a = r_init_cnt;
`else
    assign w_run    = ~RST;
    assign w_init   = 1'b0;
    assign w_init_a = '0;
`endif

    // A new read may only start when its response cannot collide with one
    // that is still waiting for the consumer.
    assign w_rd_ok   = ~r_hold_vld & ~(r_infl & ~rsp_rdy);
    assign req_rdy   = w_run & (req_wr | w_rd_ok);
    assign w_acc     = req_vld & req_rdy;
    assign init_done = w_run;

    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = '0;
        sram_d    = '0;
        if (w_init) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b1;
            sram_wen  = '1;
            sram_a    = w_init_a;
        end else if (w_acc) begin
            sram_cen  = 1'b0;
            sram_gwen = req_wr;
            sram_a    = req_addr;
            if (req_wr) begin
                sram_wen = req_bmask;
                sram_d   = req_wdata;
            end
        end
    end

    assign w_capture = r_infl & ~r_hold_vld & ~rsp_rdy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_infl     <= 1'b0;
            r_hold_vld <= 1'b0;
            r_hold_q   <= '0;
        end else begin
            r_infl <= w_acc & ~req_wr;
            if (w_capture) begin
                r_hold_vld <= 1'b1;
                r_hold_q   <= sram_q;
            end else if (r_hold_vld & rsp_rdy) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    assign rsp_vld  = (r_hold_vld | r_infl) & ~RST;
    assign rsp_data = r_hold_vld ? r_hold_q : sram_q;

endmodule
`default_nettype wire

// File: tb/tb_aq_f_spsram_ctrl_64x98.sv
`default_nettype none
// ============================================================================
// Module  : tb_aq_f_spsram_ctrl_64x98
// Brief   : Randomized scoreboard bench for aq_f_spsram_ctrl_64x98 with a
//           behavioural SRAM wrapper and a word-level reference memory.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_aq_f_spsram_ctrl_64x98;

    localparam int AW    = 6;
    localparam int DW    = 98;
    localparam int DEPTH = 64;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, req_bmask;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [DW-1:0] sram_q;

    aq_f_spsram_ctrl_64x98 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(clk), .RST(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    always #5 clk = ~clk;

    // Behavioural wrapper: bit-masked write, Q updated one cycle after a read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (sram_gwen) mem[sram_a] <= (mem[sram_a] & ~sram_wen) | (sram_d & sram_wen);
            else           sram_q      <= mem[sram_a];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        int            cyc;
    } exp_t;

    exp_t          q_exp [$];
    exp_t          e;
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            init_idx = 0;
    logic          exp_rd_ok, exp_rdy, exp_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Scoreboard producer: every accepted request updates the reference
    // memory (writes) or queues the expected read data (reads).
    always @(negedge clk) begin
        #2;
        if (!rst && req_vld && req_rdy) begin
            if (req_wr) begin
                ref_mem[req_addr]   = (ref_mem[req_addr] & ~req_bmask) | (req_wdata & req_bmask);
                ref_known[req_addr] = ref_known[req_addr] || (req_bmask == {DW{1'b1}});
            end else begin
                q_exp.push_back('{data: ref_mem[req_addr], known: ref_known[req_addr], cyc: cyc});
            end
        end
    end

    // Monitor: checks reset, init sweep, handshake rules and pops responses.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_ctrl", {123'd0, req_rdy, rsp_vld, init_done, sram_cen, sram_gwen}, 128'b00010);
            chk("reset_addr", {122'd0, sram_a}, 128'd0);
            chk("reset_wen", {30'd0, sram_wen}, 128'd0);
            chk("reset_d", {30'd0, sram_d}, 128'd0);
            q_exp.delete();
            init_idx = INIT_EN ? 0 : DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i]   = '0;
                ref_known[i] = INIT_EN;
            end
        end else if (init_idx < DEPTH) begin
            chk("init_ctrl", {122'd0, init_done, req_rdy, rsp_vld, sram_cen, sram_gwen, 1'b0}, 128'b000010);
            chk("init_addr", {122'd0, sram_a}, 128'(init_idx));
            chk("init_wen", {30'd0, sram_wen}, {30'd0, {DW{1'b1}}});
            chk("init_d", {30'd0, sram_d}, 128'd0);
            init_idx++;
        end else begin
            // A read fits if nothing is outstanding, or the single outstanding
            // response was issued last cycle and is being consumed now.
            exp_rd_ok = (q_exp.size() == 0) ||
                        (q_exp.size() == 1 && q_exp[0].cyc == cyc - 1 && rsp_rdy);
            exp_rdy   = req_wr | exp_rd_ok;
            exp_acc   = req_vld & exp_rdy;
            chk("init_done", {127'd0, init_done}, 128'd1);
            chk("req_rdy", {127'd0, req_rdy}, {127'd0, exp_rdy});
            chk("rsp_vld", {127'd0, rsp_vld}, {127'd0, q_exp.size() != 0});
            chk("sram_cen", {127'd0, sram_cen}, {127'd0, !exp_acc});
            chk("sram_a_gwen", {121'd0, sram_a, sram_gwen}, exp_acc ? {121'd0, req_addr, req_wr} : 128'd0);
            chk("sram_wen", {30'd0, sram_wen}, (exp_acc && req_wr) ? {30'd0, req_bmask} : 128'd0);
            chk("sram_d", {30'd0, sram_d}, (exp_acc && req_wr) ? {30'd0, req_wdata} : 128'd0);
            if (rsp_vld && rsp_rdy && q_exp.size() != 0) begin
                e = q_exp.pop_front();
                if (e.known) chk("rsp_data", {30'd0, rsp_data}, {30'd0, e.data});
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m);
        bit ok;
        ok        = 1'b0;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        req_bmask = m;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            #2;
            ok = req_rdy;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no req_rdy, expected accept of addr %0d", a);
        end
        @(posedge clk);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic wait_init();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            req_vld  = 1'($urandom_range(0, 1));
            req_wr   = 1'($urandom_range(0, 1));
            req_addr = 6'($urandom_range(0, DEPTH - 1));
            @(posedge clk);
            #1;
            ok = init_done;
        end
        req_vld = 1'b0;
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL init_timeout: got init_done=0, expected 1 within 200 cycles");
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [DW-1:0] w_val;

    initial begin
        rst       = 1'b1;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_bmask = '0;
        rsp_rdy   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
        wait_init();
`endif
        // First read lands straight after reset/init; zero when init is on.
        issue(1'b0, 6'd5, '0, '0);
        issue(1'b1, 6'd3, {DW{1'b1}}, {{(DW-8){1'b0}}, 8'hFF});
        issue(1'b0, 6'd3, '0, '0);

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 6'(i), rnd(), {DW{1'b1}});

        issue(1'b0, 6'd1, '0, '0);
        issue(1'b0, 6'd2, '0, '0);
        issue(1'b0, 6'd3, '0, '0);

        // Backpressure: read 7, stall three cycles, refused read, accepted write.
        issue(1'b0, 6'd7, '0, '0);
        rsp_rdy  = 1'b0;
        req_vld  = 1'b1;
        req_wr   = 1'b0;
        req_addr = 6'd9;
        @(posedge clk);
        #1;
        w_val = rnd();
        issue(1'b1, 6'd7, w_val, {DW{1'b1}});
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 6'd7, '0, '0);

        for (int i = 0; i < 1500; i++) begin
            req_vld   = ($urandom_range(0, 3) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = 6'($urandom_range(0, DEPTH - 1));
            req_wdata = rnd();
            req_bmask = ($urandom_range(0, 3) == 0) ? {DW{1'b1}} : rnd();
            rsp_rdy   = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        req_vld = 1'b0;
        rsp_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;

`ifdef AQ_SPSRAM_CTRL_INIT_EN
        // Reset in the middle of init must restart the sweep from address 0.
        pulse_reset();
        repeat (20) @(posedge clk);
        #1;
        pulse_reset();
        wait_init();
        issue(1'b0, 6'd3, '0, '0);
        issue(1'b0, 6'd7, '0, '0);
`else
        // Reset mid-traffic discards the pending response.
        issue(1'b0, 6'd4, '0, '0);
        rsp_rdy = 1'b0;
        pulse_reset();
        rsp_rdy = 1'b1;
        issue(1'b1, 6'd4, w_val, {DW{1'b1}});
        issue(1'b0, 6'd4, '0, '0);
`endif
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 128'(q_exp.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end within 1000000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
